// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants one of N requesters, holds the grant until done/abort.
// Optional RR_ARB_LOCK_EN adds a lock input that keeps the grant across done.
//
// state | meaning
// IDLE  | no grant held; arbitrate on every cycle from ptr
// GRANT | gnt/gnt_idx held until done or the granted req drops
module rr_arbiter #(
    parameter int N = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             done,
`ifdef RR_ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             busy
);

    generate
        if (N < 2) begin : g_bad_n
            $error("rr_arbiter: N must be >= 2");
        end
    endgenerate

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [IDX_W:0]   N_W  = (IDX_W+1)'(N);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t           state;
    logic [IDX_W-1:0] ptr;

    logic             done_rel;
    logic             release_ev;
    logic             arb;
    logic [IDX_W-1:0] search_ptr;
    logic [IDX_W:0]   cand;
    logic             found;
    logic [IDX_W-1:0] win;
    logic [N-1:0]     win_oh;

`ifdef RR_ARB_LOCK_EN
    assign done_rel = done & ~lock;
`else
    assign done_rel = done;
`endif

    // abort (granted req dropped) releases even when locked
    assign release_ev = (state == GRANT) && (done_rel || !req[gnt_idx]);
    assign arb        = (state == IDLE) || release_ev;

    always_comb begin
        search_ptr = ptr;
        if (release_ev) begin
            search_ptr = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_comb begin
        found  = 1'b0;
        win    = '0;
        cand   = '0;
        win_oh = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, search_ptr} + (IDX_W+1)'(i);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = cand[IDX_W-1:0];
            end
        end
        win_oh[win] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
            busy    <= 1'b0;
        end else if (arb) begin
            ptr <= search_ptr;
            if (found) begin
                state   <= GRANT;
                gnt     <= win_oh;
                gnt_idx <= win;
                busy    <= 1'b1;
            end else begin
                state   <= IDLE;
                gnt     <= '0;
                gnt_idx <= '0;
                busy    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed and randomized bench for rr_arbiter with N=4, checked against a
// queue-free reference model of the round-robin rules.
module tb_rr_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       done = 1'b0;
    logic       lock = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // reference model: m_cur = granted requester or -1, m_ptr = next priority
    int m_cur = -1;
    int m_ptr = 0;

    rr_arbiter #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
`ifdef RR_ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int start);
        int k;
        for (k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic d, input logic l);
        bit rel;
        if (m_cur < 0) begin
            m_cur = pick(r, m_ptr);
        end else begin
            rel = !r[m_cur];
`ifdef RR_ARB_LOCK_EN
            if (d && !l) rel = 1'b1;
`else
            if (d) rel = 1'b1;
`endif
            if (rel) begin
                m_ptr = (m_cur + 1) % N;
                m_cur = pick(r, m_ptr);
            end
        end
    endtask

    task automatic check_out(input string tag);
        logic [3:0] exp_gnt;
        logic       exp_busy;
        exp_gnt  = (m_cur >= 0) ? (4'b0001 << m_cur) : 4'b0000;
        exp_busy = (m_cur >= 0);
        checks++;
        assert (gnt === exp_gnt) else begin
            errors++;
            $error("FAIL %s gnt: got %b expected %b", tag, gnt, exp_gnt);
        end
        checks++;
        assert (busy === exp_busy) else begin
            errors++;
            $error("FAIL %s busy: got %b expected %b", tag, busy, exp_busy);
        end
        if (m_cur >= 0) begin
            checks++;
            assert (gnt_idx === 2'(m_cur)) else begin
                errors++;
                $error("FAIL %s gnt_idx: got %0d expected %0d", tag, gnt_idx, m_cur);
            end
        end
    endtask

    // drive inputs, advance one edge, compare 1 time unit after it
    task automatic step(input logic [3:0] r, input logic d, input logic l, input string tag);
        req  = r;
        done = d;
        lock = l;
        model_step(r, d, l);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic check_const_idx(input string tag, input int want);
        checks++;
        assert (gnt_idx === 2'(want)) else begin
            errors++;
            $error("FAIL %s: got idx %0d expected %0d", tag, gnt_idx, want);
        end
    endtask

    initial begin
        // reset values
        #2;
        check_out("reset");
        checks++;
        assert (gnt_idx === 2'd0) else begin
            errors++;
            $error("FAIL reset_idx: got %0d expected 0", gnt_idx);
        end

        // scenario 1: two requesters alternate on done
        req = 4'b0101;
        #6 rst_n = 1'b1;
        @(negedge clk);
        step(4'b0101, 1'b0, 1'b0, "s1_first");
        check_const_idx("s1_first_const", 0);
        step(4'b0101, 1'b1, 1'b0, "s1_done1");
        check_const_idx("s1_done1_const", 2);
        step(4'b0101, 1'b1, 1'b0, "s1_done2");
        step(4'b0101, 1'b0, 1'b0, "s1_hold");
        step(4'b0111, 1'b0, 1'b0, "s1_no_preempt");

        // scenario 2: all requesting, done every cycle -> one grant per cycle
        step(4'b0000, 1'b1, 1'b0, "s2_drain");
        step(4'b0000, 1'b0, 1'b0, "s2_idle");
        for (int i = 0; i < 6; i++) begin
            step(4'b1111, 1'b1, 1'b0, "s2_rotate");
        end

        // scenario 3: abort by dropping the granted req
        step(4'b0000, 1'b1, 1'b0, "s3_drain");
        step(4'b0010, 1'b0, 1'b0, "s3_grant1");
        check_const_idx("s3_grant1_const", 1);
        step(4'b0000, 1'b0, 1'b0, "s3_abort");
        step(4'b0011, 1'b0, 1'b0, "s3_wrap");
        check_const_idx("s3_wrap_const", 0);

        // scenario 4: done in IDLE is ignored
        step(4'b0000, 1'b1, 1'b0, "s4_release");
        step(4'b0000, 1'b1, 1'b0, "s4_idle_done");
        step(4'b1000, 1'b0, 1'b0, "s4_grant3");
        check_const_idx("s4_grant3_const", 3);

`ifdef RR_ARB_LOCK_EN
        // scenario 5: lock holds grant across done
        step(4'b1111, 1'b1, 1'b0, "s5_to0");
        step(4'b1111, 1'b1, 1'b0, "s5_to1");
        step(4'b1111, 1'b1, 1'b1, "s5_locked");
        check_const_idx("s5_locked_const", 1);
        step(4'b1111, 1'b1, 1'b0, "s5_unlock");
        check_const_idx("s5_unlock_const", 2);
        step(4'b0101, 1'b0, 1'b1, "s5_abort_locked");
`endif

        // scenario 6: asynchronous reset mid-grant
        step(4'b0000, 1'b1, 1'b0, "s6_drain");
        step(4'b0100, 1'b0, 1'b0, "s6_grant2");
        check_const_idx("s6_grant2_const", 2);
        #3 rst_n = 1'b0;
        m_cur = -1;
        m_ptr = 0;
        #1;
        check_out("s6_async_rst");
        req = 4'b0110;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0110, 1'b0, 1'b0, "s6_after_rst");
        check_const_idx("s6_after_rst_const", 1);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            logic       d;
            logic       l;
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r = '0;
            d = ($urandom_range(0, 2) != 0);
`ifdef RR_ARB_LOCK_EN
            l = ($urandom_range(0, 3) == 0);
`else
            l = 1'b0;
`endif
            // keep the granted requester asserted most of the time
            if (m_cur >= 0 && $urandom_range(0, 4) != 0) r[m_cur] = 1'b1;
            step(r, d, l, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
